seg7_countdown: RTL and testbench

//  MM:SS countdown timer with a 4-digit multiplexed 7-segment driver. Sits directly

---
 rtl/seg7_pkg.sv | 65 ++++++
 rtl/seg7_decode.sv | 26 ++
 rtl/seg7_countdown.sv | 154 +++++++++++++++
 tb/tb_seg7_countdown.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared types and constants for the MM:SS countdown timer and its 7-segment driver.
// Also holds the preset clamp and the BCD borrow-chain helpers.
package seg7_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Active-high {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [3:0] BLANK_CODE = 4'hF;

    function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] max);
        logic [3:0] r;
        if (d > max) begin
            r = max;
        end else begin
            r = d;
        end
        return r;
    endfunction

    function automatic logic [15:0] sanitise_preset(input logic [15:0] p);
        return {clamp_digit(p[15:12], 4'd5), clamp_digit(p[11:8], 4'd9),
                clamp_digit(p[7:4], 4'd5), clamp_digit(p[3:0], 4'd9)};
    endfunction

    // One-second BCD decrement; callers never pass 00:00.
    function automatic logic [15:0] bcd_dec_mmss(input logic [15:0] c);
        logic [15:0] r;
        r = c;
        if (c[3:0] != 4'd0) begin
            r[3:0] = c[3:0] - 4'd1;
        end else begin
            r[3:0] = 4'd9;
            if (c[7:4] != 4'd0) begin
                r[7:4] = c[7:4] - 4'd1;
            end else begin
                r[7:4] = 4'd5;
                if (c[11:8] != 4'd0) begin
                    r[11:8] = c[11:8] - 4'd1;
                end else begin
                    r[11:8]  = 4'd9;
                    r[15:12] = c[15:12] - 4'd1;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to active-high 7-segment decoder; codes A-F show blank.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // Digit pattern lookup
    always_comb begin
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_countdown.sv
// MM:SS countdown timer with start/pause/clear control and a 4-digit multiplexed
// 7-segment driver; divider square waves are edge-detected into one-cycle enables.
module seg7_countdown
    import seg7_pkg::*;
#(
    parameter bit         SEG_ACT_LOW = 1'b1,
    parameter logic [1:0] DP_DIGIT    = 2'd2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clk_1s,
    input  logic        clk_7seg,
    input  logic        btn_start,
    input  logic        btn_clear,
    input  logic [15:0] sw_time,
    output logic [3:0]  an,
    output logic [7:0]  seg,
    output logic        done
);

    logic        clk_1s_d_q, clk_7seg_d_q, btn_start_d_q, btn_clear_d_q;
    state_t      state_q, state_d;
    logic [15:0] count_q, count_d;
    logic [1:0]  idx_q, idx_d;
    logic [3:0]  an_q, an_d;
    logic [7:0]  seg_q, seg_d;
    logic        done_q, done_d;

    logic        tick_1s_s, tick_scan_s, start_p_s, clear_p_s;
    logic [15:0] preset_s, disp_s;
    logic [3:0]  digit_s;
    logic [6:0]  pat_s;

    assign tick_1s_s   = clk_1s & ~clk_1s_d_q;
    assign tick_scan_s = clk_7seg & ~clk_7seg_d_q;
    assign start_p_s   = btn_start & ~btn_start_d_q;
    assign clear_p_s   = btn_clear & ~btn_clear_d_q;
    assign preset_s    = sanitise_preset(sw_time);
    assign disp_s      = (state_q == ST_IDLE) ? preset_s : count_q;

    // Select the BCD digit for the current scan position
    always_comb begin
        case (idx_q)
            2'd0:    digit_s = disp_s[3:0];
            2'd1:    digit_s = disp_s[7:4];
            2'd2:    digit_s = disp_s[11:8];
            2'd3:    digit_s = disp_s[15:12];
            default: digit_s = BLANK_CODE;
        endcase
    end

    seg7_decode u_decode (
        .bcd (digit_s),
        .seg (pat_s)
    );

    // Next-state logic: clear has priority, then start, then the 1 s tick
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        if (clear_p_s) begin
            state_d = ST_IDLE;
            count_d = 16'h0000;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_p_s && (preset_s != 16'h0000)) begin
                        state_d = ST_RUN;
                        count_d = preset_s;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (start_p_s) begin
                        state_d = ST_PAUSE;
                    end else if (tick_1s_s && (count_q == 16'h0001)) begin
                        state_d = ST_DONE;
                        count_d = 16'h0000;
                    end else if (tick_1s_s && (count_q != 16'h0000)) begin
                        count_d = bcd_dec_mmss(count_q);
                    end else begin
                        count_d = count_q;
                    end
                end
                ST_PAUSE: begin
                    if (start_p_s) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_PAUSE;
                    end
                end
                ST_DONE: begin
                    if (start_p_s) begin
                        state_d = ST_IDLE;
                        count_d = 16'h0000;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    count_d = 16'h0000;
                end
            endcase
        end
    end

    // Scan outputs latch the digit at idx on each scan tick, then idx advances
    always_comb begin
        done_d = (state_d == ST_DONE);
        if (tick_scan_s) begin
            idx_d = idx_q + 2'd1;
            an_d  = (4'b0001 << idx_q) ^ {4{SEG_ACT_LOW}};
            seg_d = {(idx_q == DP_DIGIT), pat_s} ^ {8{SEG_ACT_LOW}};
        end else begin
            idx_d = idx_q;
            an_d  = an_q;
            seg_d = seg_q;
        end
    end

    // State, counter, edge history and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clk_1s_d_q    <= 1'b0;
            clk_7seg_d_q  <= 1'b0;
            btn_start_d_q <= 1'b0;
            btn_clear_d_q <= 1'b0;
            state_q       <= ST_IDLE;
            count_q       <= 16'h0000;
            idx_q         <= 2'd0;
            an_q          <= {4{SEG_ACT_LOW}};
            seg_q         <= {8{SEG_ACT_LOW}};
            done_q        <= 1'b0;
        end else begin
            clk_1s_d_q    <= clk_1s;
            clk_7seg_d_q  <= clk_7seg;
            btn_start_d_q <= btn_start;
            btn_clear_d_q <= btn_clear;
            state_q       <= state_d;
            count_q       <= count_d;
            idx_q         <= idx_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            done_q        <= done_d;
        end
    end

    assign an   = an_q;
    assign seg  = seg_q;
    assign done = done_q;

endmodule

// File: tb/tb_seg7_countdown.sv
// Randomized and directed bench for seg7_countdown; the reference model tracks the
// remaining time as a plain number of seconds and rebuilds display digits arithmetically.
module tb_seg7_countdown;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clk_1s = 1'b0;
    logic        clk_7seg = 1'b0;
    logic        btn_start = 1'b0;
    logic        btn_clear = 1'b0;
    logic [15:0] sw_time = 16'h0000;
    logic [3:0]  an;
    logic [7:0]  seg;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;

    int m_state = M_IDLE;
    int m_secs  = 0;
    int m_idx   = 0;

    logic [6:0] pat_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    seg7_countdown #(.SEG_ACT_LOW(1'b1), .DP_DIGIT(2'd2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clk_1s    (clk_1s),
        .clk_7seg  (clk_7seg),
        .btn_start (btn_start),
        .btn_clear (btn_clear),
        .sw_time   (sw_time),
        .an        (an),
        .seg       (seg),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int min_int(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Preset as seconds after clamping each digit to its legal range
    function automatic int preset_secs(input logic [15:0] sw);
        int m10, m1, s10, s1;
        m10 = min_int(int'(sw[15:12]), 5);
        m1  = min_int(int'(sw[11:8]), 9);
        s10 = min_int(int'(sw[7:4]), 5);
        s1  = min_int(int'(sw[3:0]), 9);
        return (m10 * 10 + m1) * 60 + s10 * 10 + s1;
    endfunction

    function automatic int digit_of(input int secs, input int pos);
        int mm, ss;
        mm = secs / 60;
        ss = secs % 60;
        case (pos)
            0:       return ss % 10;
            1:       return ss / 10;
            2:       return mm % 10;
            default: return mm / 10;
        endcase
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference behaviour for one input event (clear > start > tick)
    task automatic model_event(input bit st, input bit cl, input bit tk);
        int p;
        p = preset_secs(sw_time);
        if (cl) begin
            m_state = M_IDLE;
            m_secs  = 0;
        end else if (st) begin
            if (m_state == M_IDLE && p != 0) begin
                m_state = M_RUN;
                m_secs  = p;
            end else if (m_state == M_RUN) begin
                m_state = M_PAUSE;
            end else if (m_state == M_PAUSE) begin
                m_state = M_RUN;
            end else if (m_state == M_DONE) begin
                m_state = M_IDLE;
                m_secs  = 0;
            end
        end else if (tk && m_state == M_RUN && m_secs > 0) begin
            m_secs = m_secs - 1;
            if (m_secs == 0) m_state = M_DONE;
        end
    endtask

    task automatic pulse(input bit st, input bit cl, input bit tk);
        @(negedge clk);
        btn_start = st;
        btn_clear = cl;
        clk_1s    = tk;
        model_event(st, cl, tk);
        cycles(2);
        btn_start = 1'b0;
        btn_clear = 1'b0;
        clk_1s    = 1'b0;
        cycles(2);
        check_eq("done", 32'(done), 32'(m_state == M_DONE));
    endtask

    task automatic scan_check(input string tag);
        int dv, d;
        logic [7:0] exp_seg;
        logic [3:0] exp_an;
        @(negedge clk);
        clk_7seg = 1'b1;
        dv = (m_state == M_IDLE) ? preset_secs(sw_time) : m_secs;
        d  = digit_of(dv, m_idx);
        exp_an  = ~(4'b0001 << m_idx);
        exp_seg = ~{(m_idx == 2), pat_tab[d]};
        cycles(2);
        check_eq({tag, "_an"}, 32'(an), 32'(exp_an));
        check_eq({tag, "_seg"}, 32'(seg), 32'(exp_seg));
        clk_7seg = 1'b0;
        cycles(1);
        m_idx = (m_idx + 1) % 4;
    endtask

    task automatic check_display(input string tag);
        repeat (4) scan_check(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        clk_1s    = 1'b0;
        clk_7seg  = 1'b0;
        btn_start = 1'b0;
        btn_clear = 1'b0;
        cycles(2);
        check_eq("rst_an", 32'(an), 32'h0000000F);
        check_eq("rst_seg", 32'(seg), 32'h000000FF);
        check_eq("rst_done", 32'(done), 32'h0);
        rst_n   = 1'b1;
        m_state = M_IDLE;
        m_secs  = 0;
        m_idx   = 0;
        cycles(1);
        check_eq("blank_before_scan", 32'(an), 32'h0000000F);
    endtask

    initial begin
        int r;
        do_reset();
        check_display("reset_idle");

        // 01:03 countdown across the minute boundary
        sw_time = 16'h0103;
        pulse(1'b1, 1'b0, 1'b0);
        check_display("run_0103");
        repeat (3) begin
            pulse(1'b0, 1'b0, 1'b1);
            check_display("run_dec");
        end
        pulse(1'b0, 1'b0, 1'b1);
        check_display("run_0059");

        // Short count into DONE and acknowledge
        pulse(1'b0, 1'b1, 1'b0);
        sw_time = 16'h0002;
        pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b0, 1'b0, 1'b1);
        pulse(1'b0, 1'b0, 1'b1);
        check_eq("done_hi", 32'(done), 32'h1);
        check_display("done_0000");
        pulse(1'b1, 1'b0, 1'b0);
        check_eq("done_lo", 32'(done), 32'h0);
        check_display("ack_idle");

        // Pause freezes the count; a tick coinciding with start is dropped
        sw_time = 16'h0230;
        pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b0, 1'b0, 1'b1);
        pulse(1'b1, 1'b0, 1'b1);
        repeat (5) pulse(1'b0, 1'b0, 1'b1);
        check_display("paused");
        pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b0, 1'b0, 1'b1);
        check_display("resumed");

        // Sanitised preset display and zero preset refused
        pulse(1'b0, 1'b1, 1'b0);
        sw_time = 16'h7A9F;
        check_display("sanitise");
        sw_time = 16'h0000;
        pulse(1'b1, 1'b0, 1'b0);
        sw_time = 16'h0412;
        check_display("zero_start_idle");

        // Clear and start together from RUN
        pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b0, 1'b0, 1'b1);
        pulse(1'b1, 1'b1, 1'b0);
        check_display("clear_wins");

        // Reset mid-count
        pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b0, 1'b0, 1'b1);
        do_reset();
        check_display("reset_midcount");

        // Randomized event mix
        for (int i = 0; i < 300; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 50) begin
                pulse(1'b0, 1'b0, 1'b1);
            end else if (r < 62) begin
                pulse(1'b1, 1'b0, 1'b0);
            end else if (r < 65) begin
                pulse(1'b0, 1'b1, 1'b0);
            end else if (r < 70) begin
                pulse(1'b1, 1'b0, 1'b1);
            end else if (r < 73) begin
                pulse(1'b1, 1'b1, 1'b1);
            end else if (r < 77) begin
                sw_time = 16'($urandom);
            end else if (r < 82) begin
                sw_time = 16'($urandom) & 16'h0017;
            end else begin
                check_display("rand");
            end
        end
        check_display("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
